otter_csr: RTL and testbench
============================

OTTER_CSR -- requirements
Module: otter_csr

Interface
REQ-001 SHALL have parameter MTVEC_RST, default 32'h0000_0000, MTVEC value after reset.
REQ-002 SHALL have parameter MCAUSE_INT, default 32'h8000_000B, cause value latched on interrupt entry.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-005 SHALL have port CSR_WE  in  1  write strobe for the addressed CSR.
REQ-006 SHALL have port ADDR  in  12  CSR address, used for both read and write.
REQ-007 SHALL have port WD  in  32  write data; the ALU has already applied the csrrw/csrrs/csrrc operation.
REQ-008 SHALL have port PC  in  32  PC of the interrupted instruction.
REQ-009 SHALL have port INT_TAKEN  in  1  one-cycle pulse marking interrupt entry.
REQ-010 SHALL have port MRET_EXEC  in  1  one-cycle pulse marking mret execution.
REQ-011 SHALL have port RD  out  32  combinational read data for ADDR; this is the CSR_RD operand.
REQ-012 SHALL have port CSR_MIE  out  1  MSTATUS.MIE, gates the external interrupt.
REQ-013 SHALL have port CSR_MEPC  out  32  MEPC, the mret target.
REQ-014 SHALL have port CSR_MTVEC  out  32  MTVEC, the trap target.

Function
REQ-015 SHALL implement MSTATUS 0x300 (bit3 MIE, bit7 MPIE, all other bits read 0), MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MCYCLE 0xB00, MCYCLEH 0xB80.
REQ-016 SHALL drive RD from ADDR with zero latency: the full register for every implemented CSR, 0 for an unmapped address.
REQ-017 SHALL, with CSR_WE=1, update the addressed CSR to WD at the next edge: MSTATUS keeps WD bits 3 and 7 only; MTVEC and MEPC clear WD[1:0].
REQ-018 SHALL ignore writes to unmapped addresses, with no state change.
REQ-019 SHALL, on INT_TAKEN: MEPC<=PC; MPIE<=MIE; MIE<=0; MCAUSE<=MCAUSE_INT, all in the same edge.
REQ-020 SHALL, on MRET_EXEC: MIE<=MPIE; MPIE<=1.
REQ-021 SHALL apply priority RST > INT_TAKEN > MRET_EXEC > CSR_WE; a lower-priority event in the same cycle is discarded entirely.
REQ-022 SHALL increment the 64-bit MCYCLE every cycle and wrap from 2^64-1 to 0.
REQ-023 SHALL give a CSR write to MCYCLE or MCYCLEH precedence over the increment in that cycle; the written half takes WD, the other half holds.
REQ-024 SHALL reflect every state update on RD and the status outputs one cycle after the causing edge, never in the same cycle.

Reset
REQ-025 SHALL, on RST, set MSTATUS=0, MTVEC=MTVEC_RST, MEPC=0, MCAUSE=0, MCYCLE=0.
REQ-026 SHALL therefore hold outputs CSR_MIE=0, CSR_MEPC=0, CSR_MTVEC=MTVEC_RST and RD=per-address value of reset state after reset.
REQ-027 SHALL let RST asserted mid-interrupt-entry override INT_TAKEN, leaving MEPC=0.

Structure
REQ-028 SHALL place CSR address constants, MIE/MPIE bit positions and the MCAUSE_INT default in shared package otter_csr_pkg.
REQ-029 SHALL implement the 64-bit counter with half-word write as sub-module otter_cycle_cnt.

Verification
REQ-030 SHALL cover: reset, then ADDR=0x305 -> RD=MTVEC_RST; ADDR=0x300 -> RD=0.
REQ-031 SHALL cover: CSR_WE, ADDR=0x300, WD=0xFFFF_FFFF -> next cycle RD=0x0000_0088, CSR_MIE=1.
REQ-032 SHALL cover: MIE=1, INT_TAKEN, PC=0x0000_0124 -> CSR_MEPC=0x124, CSR_MIE=0, MSTATUS=0x80, MCAUSE=0x8000_000B.
REQ-033 SHALL cover: MRET_EXEC after REQ-032 -> CSR_MIE=1, MSTATUS=0x88.
REQ-034 SHALL cover: INT_TAKEN with CSR_WE to 0x341 (WD=0x500), PC=0x200 -> MEPC=0x200.
REQ-035 SHALL cover: write MCYCLE=0xFFFF_FFFF and MCYCLEH=0 -> two cycles later MCYCLEH=1, MCYCLE=1; write to 0x7C0 -> no CSR changes.

Source files
------------

// File: rtl/otter_csr_pkg.sv
// Shared constants for the OTTER machine-mode CSR file: addresses,
// MSTATUS bit positions and the default interrupt cause.
package otter_csr_pkg;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [31:0] MCAUSE_INT_DEF = 32'h8000_000B;
endpackage

// File: rtl/otter_cycle_cnt.sv
// 64-bit free-running cycle counter; a half-word write replaces that half
// and holds the other half for the cycle instead of incrementing.
module otter_cycle_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wd,
  output logic [63:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (we_lo) cnt <= {cnt[63:32], wd};
    else if (we_hi) cnt <= {wd, cnt[31:0]};
    else            cnt <= cnt + 64'd1;
  end
endmodule

// File: rtl/otter_csr.sv
// OTTER machine-mode CSR file: MSTATUS/MTVEC/MEPC/MCAUSE/MCYCLE with
// interrupt entry and mret sequencing.
module otter_csr
  import otter_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST  = 32'h0000_0000,
  parameter logic [31:0] MCAUSE_INT = MCAUSE_INT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CSR_WE,
  input  logic [11:0] ADDR,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  input  logic        INT_TAKEN,
  input  logic        MRET_EXEC,
  output logic [31:0] RD,
  output logic        CSR_MIE,
  output logic [31:0] CSR_MEPC,
  output logic [31:0] CSR_MTVEC
);
  logic        mie, mpie;
  logic [31:0] mtvec, mepc, mcause;
  logic [63:0] mcycle;
  logic [31:0] mstatus;
  logic        csr_wr;

  // Interrupt entry and mret swallow any CSR write issued alongside them.
  assign csr_wr = CSR_WE & ~INT_TAKEN & ~MRET_EXEC;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mtvec  <= MTVEC_RST;
      mepc   <= '0;
      mcause <= '0;
    end else if (INT_TAKEN) begin
      mepc   <= PC;
      mpie   <= mie;
      mie    <= 1'b0;
      mcause <= MCAUSE_INT;
    end else if (MRET_EXEC) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csr_wr) begin
      case (ADDR)
        ADDR_MSTATUS: begin
          mie  <= WD[MIE_BIT];
          mpie <= WD[MPIE_BIT];
        end
        ADDR_MTVEC:  mtvec  <= {WD[31:2], 2'b00};
        ADDR_MEPC:   mepc   <= {WD[31:2], 2'b00};
        ADDR_MCAUSE: mcause <= WD;
        default: ;
      endcase
    end
  end

  otter_cycle_cnt u_cycle_cnt (
    .clk   (CLK),
    .rst   (RST),
    .we_lo (csr_wr && (ADDR == ADDR_MCYCLE)),
    .we_hi (csr_wr && (ADDR == ADDR_MCYCLEH)),
    .wd    (WD),
    .cnt   (mcycle)
  );

  always_comb begin
    mstatus           = '0;
    mstatus[MIE_BIT]  = mie;
    mstatus[MPIE_BIT] = mpie;
  end

  always_comb begin
    case (ADDR)
      ADDR_MSTATUS: RD = mstatus;
      ADDR_MTVEC:   RD = mtvec;
      ADDR_MEPC:    RD = mepc;
      ADDR_MCAUSE:  RD = mcause;
      ADDR_MCYCLE:  RD = mcycle[31:0];
      ADDR_MCYCLEH: RD = mcycle[63:32];
      default:      RD = '0;
    endcase
  end

  assign CSR_MIE   = mie;
  assign CSR_MEPC  = mepc;
  assign CSR_MTVEC = mtvec;
endmodule

// File: tb/tb_otter_csr.sv
// Directed vector bench for otter_csr: table of single-edge transactions
// plus hand sequences for the cycle counter.
module tb_otter_csr;
  localparam logic [31:0] MTVEC_R = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST, CSR_WE, INT_TAKEN, MRET_EXEC;
  logic [11:0] ADDR;
  logic [31:0] WD, PC, RD, CSR_MEPC, CSR_MTVEC;
  logic        CSR_MIE;

  int checks = 0;
  int errors = 0;

  otter_csr #(.MTVEC_RST(MTVEC_R), .MCAUSE_INT(32'h8000_000B)) dut (
    .CLK(CLK), .RST(RST), .CSR_WE(CSR_WE), .ADDR(ADDR), .WD(WD), .PC(PC),
    .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC), .RD(RD), .CSR_MIE(CSR_MIE),
    .CSR_MEPC(CSR_MEPC), .CSR_MTVEC(CSR_MTVEC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, we, itk, mret;
    logic [11:0] addr;
    logic [31:0] wd, pc;
    logic [11:0] chk_addr;
    logic [31:0] exp_rd;
    logic        exp_mie;
    logic [31:0] exp_mepc, exp_mtvec;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    RST = 0; CSR_WE = 0; INT_TAKEN = 0; MRET_EXEC = 0; WD = '0; PC = '0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  initial begin
    //          rst we itk mret addr    wd            pc            chk     exp_rd        mie  mepc          mtvec
    vt[0]  = '{1, 0, 0, 0, 12'h000, 32'h0,        32'h0,        12'h305, MTVEC_R,       0, 32'h0,        MTVEC_R};
    vt[1]  = '{1, 0, 0, 0, 12'h000, 32'h0,        32'h0,        12'h300, 32'h0,         0, 32'h0,        MTVEC_R};
    vt[2]  = '{0, 1, 0, 0, 12'h300, 32'hFFFF_FFFF, 32'h0,       12'h300, 32'h88,        1, 32'h0,        MTVEC_R};
    vt[3]  = '{0, 0, 1, 0, 12'h000, 32'h0,        32'h124,      12'h341, 32'h124,       0, 32'h124,      MTVEC_R};
    vt[4]  = '{0, 0, 0, 0, 12'h000, 32'h0,        32'h0,        12'h300, 32'h80,        0, 32'h124,      MTVEC_R};
    vt[5]  = '{0, 0, 0, 0, 12'h000, 32'h0,        32'h0,        12'h342, 32'h8000_000B, 0, 32'h124,      MTVEC_R};
    vt[6]  = '{0, 0, 0, 1, 12'h000, 32'h0,        32'h0,        12'h300, 32'h88,        1, 32'h124,      MTVEC_R};
    vt[7]  = '{0, 1, 1, 0, 12'h341, 32'h500,      32'h200,      12'h341, 32'h200,       0, 32'h200,      MTVEC_R};
    vt[8]  = '{0, 1, 0, 0, 12'h305, 32'h2003,     32'h0,        12'h305, 32'h2000,      0, 32'h200,      32'h2000};
    vt[9]  = '{0, 1, 0, 0, 12'h341, 32'h333,      32'h0,        12'h341, 32'h330,       0, 32'h330,      32'h2000};
    vt[10] = '{0, 1, 0, 0, 12'h7C0, 32'hFFFF_FFFF, 32'h0,       12'h7C0, 32'h0,         0, 32'h330,      32'h2000};
    vt[11] = '{0, 1, 0, 1, 12'h300, 32'h0,        32'h0,        12'h300, 32'h88,        1, 32'h330,      32'h2000};
    vt[12] = '{1, 0, 1, 0, 12'h000, 32'h0,        32'h444,      12'h341, 32'h0,         0, 32'h0,        MTVEC_R};
    vt[13] = '{0, 1, 0, 0, 12'h342, 32'h1234,     32'h0,        12'h342, 32'h1234,      0, 32'h0,        MTVEC_R};
    vt[14] = '{0, 1, 0, 0, 12'h300, 32'h8,        32'h0,        12'h300, 32'h8,         1, 32'h0,        MTVEC_R};
    vt[15] = '{0, 0, 0, 1, 12'h000, 32'h0,        32'h0,        12'h300, 32'h80,        0, 32'h0,        MTVEC_R};
    vt[16] = '{0, 1, 0, 0, 12'h300, 32'h8,        32'h0,        12'h300, 32'h8,         1, 32'h0,        MTVEC_R};
    vt[17] = '{0, 0, 1, 1, 12'h000, 32'h0,        32'h300,      12'h300, 32'h80,        0, 32'h300,      MTVEC_R};

    idle(); ADDR = '0;
    for (int i = 0; i < 18; i++) begin
      RST = vt[i].rst; CSR_WE = vt[i].we; INT_TAKEN = vt[i].itk; MRET_EXEC = vt[i].mret;
      ADDR = vt[i].addr; WD = vt[i].wd; PC = vt[i].pc;
      tick();
      idle(); ADDR = vt[i].chk_addr; #1;
      chk($sformatf("v%0d_rd", i), RD, vt[i].exp_rd);
      chk($sformatf("v%0d_mie", i), {31'b0, CSR_MIE}, {31'b0, vt[i].exp_mie});
      chk($sformatf("v%0d_mepc", i), CSR_MEPC, vt[i].exp_mepc);
      chk($sformatf("v%0d_mtvec", i), CSR_MTVEC, vt[i].exp_mtvec);
    end

    // Cycle counter: reset, increment, half-word writes, carry and wrap.
    RST = 1; tick(); idle(); ADDR = 12'hB00; #1;
    chk("cyc_rst", RD, 32'h0);
    tick(); chk("cyc_inc", RD, 32'h1);
    CSR_WE = 1; ADDR = 12'hB00; WD = 32'hFFFF_FFFF; tick();
    ADDR = 12'hB80; WD = 32'h0; tick();
    idle(); ADDR = 12'hB00; #1;
    chk("cyc_lo_held", RD, 32'hFFFF_FFFF);
    tick(); tick();
    chk("cyc_lo_carry", RD, 32'h1);
    ADDR = 12'hB80; #1;
    chk("cyc_hi_carry", RD, 32'h1);
    CSR_WE = 1; ADDR = 12'hB00; WD = 32'hFFFF_FFFF; tick();
    ADDR = 12'hB80; tick();
    idle(); #1;
    chk("cyc_hi_max", RD, 32'hFFFF_FFFF);
    tick();
    chk("cyc_hi_wrap", RD, 32'h0);
    ADDR = 12'hB00; #1;
    chk("cyc_lo_wrap", RD, 32'h0);
    // A counter write alongside interrupt entry is dropped; counting continues.
    CSR_WE = 1; INT_TAKEN = 1; WD = 32'h5; PC = 32'h40; tick();
    idle(); #1;
    chk("cyc_int_drop", RD, 32'h1);
    CSR_WE = 1; ADDR = 12'h7C0; WD = 32'h5; tick();
    idle(); ADDR = 12'hB00; #1;
    chk("cyc_unmapped", RD, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
